// File: rtl/f_d_pipe_reg.sv
// F->D pipeline register: captures the fetched instruction for decode,
// flags fetch address errors (AdEL), carries the delay-slot flag and
// counts real instructions delivered to D.
module f_d_pipe_reg #(
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER  = 32'h0000_4180,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        F_BD,
  input  logic        stall,
  input  logic        flush,
  input  logic        Req,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_BD,
  output logic [4:0]  D_ExcCode,
  output logic        D_Valid,
  output logic [31:0] D_FetchCnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc;
    logic        vld;
  } d_reg_t;

  d_reg_t      d_q, d_nxt;
  logic [31:0] cnt_q, cnt_nxt;
  logic        adel;

  // Fetch address error: misaligned or outside the text segment (unsigned).
  always_comb begin
    adel = (F_PC[1:0] != 2'b00) | (F_PC < TEXT_LO) | (F_PC > TEXT_HI);
  end

  // Next D contents; exception request beats stall, stall beats flush.
  always_comb begin
    d_nxt   = d_q;
    cnt_nxt = cnt_q;
    if (Req) begin
      d_nxt = '{pc: HANDLER, instr: 32'h0, bd: 1'b0, exc: 5'd0, vld: 1'b0};
    end else if (stall) begin
      d_nxt   = d_q;
    end else if (flush) begin
      // Bubble keeps the real PC/BD so a later interrupt reports a correct EPC.
      d_nxt = '{pc: F_PC, instr: 32'h0, bd: F_BD, exc: 5'd0, vld: 1'b0};
    end else begin
      d_nxt = '{pc:    F_PC,
                instr: adel ? 32'h0 : F_Instr,
                bd:    F_BD,
                exc:   adel ? EXC_ADEL : 5'd0,
                vld:   1'b1};
      // AdEL fetches are real fetches carrying an exception, so they count.
      cnt_nxt = cnt_q + 32'd1;
    end
  end

  // D register and fetch counter, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q   <= '{pc: TEXT_LO, instr: 32'h0, bd: 1'b0, exc: 5'd0, vld: 1'b0};
      cnt_q <= 32'h0;
    end else begin
      d_q   <= d_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign D_PC       = d_q.pc;
  assign D_Instr    = d_q.instr;
  assign D_BD       = d_q.bd;
  assign D_ExcCode  = d_q.exc;
  assign D_Valid    = d_q.vld;
  assign D_FetchCnt = cnt_q;

endmodule

// File: tb/tb_f_d_pipe_reg.sv
// Self-checking bench for f_d_pipe_reg: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the D stage.
module tb_f_d_pipe_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] F_PC = 32'h0, F_Instr = 32'h0;
  logic        F_BD = 1'b0, stall = 1'b0, flush = 1'b0, Req = 1'b0;
  logic [31:0] D_PC, D_Instr, D_FetchCnt;
  logic        D_BD, D_Valid;
  logic [4:0]  D_ExcCode;

  int vectors = 0;
  int miscompares = 0;

  // reference state of the D stage
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_bd, m_vld;
  logic [4:0]  m_exc;

  f_d_pipe_reg dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .F_Instr(F_Instr), .F_BD(F_BD),
    .stall(stall), .flush(flush), .Req(Req), .D_PC(D_PC), .D_Instr(D_Instr),
    .D_BD(D_BD), .D_ExcCode(D_ExcCode), .D_Valid(D_Valid), .D_FetchCnt(D_FetchCnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_exc = 0; m_vld = 0; m_cnt = 0;
  endfunction

  // One clock edge of the D stage, written straight from the behaviour rules.
  function automatic void model_edge();
    bit bad;
    bad = (F_PC % 4 != 0) || (F_PC < 32'h3000) || (F_PC > 32'h6FFC);
    if (Req) begin
      m_pc = 32'h4180; m_instr = 0; m_bd = 0; m_exc = 0; m_vld = 0;
    end else if (stall) begin
      // hold everything
    end else if (flush) begin
      m_pc = F_PC; m_bd = F_BD; m_instr = 0; m_exc = 0; m_vld = 0;
    end else begin
      m_pc = F_PC; m_bd = F_BD; m_vld = 1;
      m_instr = bad ? 32'h0 : F_Instr;
      m_exc   = bad ? 5'd4 : 5'd0;
      m_cnt   = m_cnt + 1;
    end
  endfunction

  // Advance one rising edge, update the model, land 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic bd,
                       input logic st, input logic fl, input logic rq);
    F_PC = pc; F_Instr = ins; F_BD = bd; stall = st; flush = fl; Req = rq;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt} !==
        {m_pc, m_instr, m_bd, m_exc, m_vld, m_cnt}) begin
      miscompares++;
      $display("FAIL reset: got pc=%h ins=%h bd=%b exc=%0d v=%b cnt=%0d want pc=%h ins=%h bd=%b exc=%0d v=%b cnt=%0d",
               D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt, m_pc, m_instr, m_bd, m_exc, m_vld, m_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    drive(32'h3000, 32'h2401_0001, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({D_PC, D_Instr, D_ExcCode, D_Valid, D_FetchCnt} !==
        {32'h3000, 32'h2401_0001, 5'd0, 1'b1, 32'd1}) begin
      miscompares++;
      $display("FAIL first_load: got pc=%h ins=%h exc=%0d v=%b cnt=%0d want 3000 24010001 0 1 1",
               D_PC, D_Instr, D_ExcCode, D_Valid, D_FetchCnt);
    end
  endtask

  task automatic test_adel();
    logic [31:0] pcs [5] = '{32'h3002, 32'h2FFC, 32'h7000, 32'h6FFC, 32'h3000};
    for (int i = 0; i < 5; i++) begin
      drive(pcs[i], 32'hDEAD_0000 + i, i[0], 0, 0, 0);
      tick();
      vectors++;
      if ({D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt} !==
          {m_pc, m_instr, m_bd, m_exc, m_vld, m_cnt}) begin
        miscompares++;
        $display("FAIL adel_%h: got pc=%h ins=%h exc=%0d v=%b cnt=%0d want pc=%h ins=%h exc=%0d v=%b cnt=%0d",
                 pcs[i], D_PC, D_Instr, D_ExcCode, D_Valid, D_FetchCnt, m_pc, m_instr, m_exc, m_vld, m_cnt);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_cnt;
    drive(32'h3004, 32'h1111_2222, 0, 0, 0, 0);
    tick();
    held_cnt = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(32'h3008, 32'h3333_4444, 0, 1, 0, 0);
      tick();
      vectors++;
      if ({D_PC, D_Instr, D_Valid, D_FetchCnt} !== {32'h3004, 32'h1111_2222, 1'b1, held_cnt}) begin
        miscompares++;
        $display("FAIL stall_hold: got pc=%h ins=%h v=%b cnt=%0d want 3004 11112222 1 %0d",
                 D_PC, D_Instr, D_Valid, D_FetchCnt, held_cnt);
      end
    end
    stall = 0;
    tick();
    vectors++;
    if ({D_PC, D_Instr, D_FetchCnt} !== {32'h3008, 32'h3333_4444, held_cnt + 32'd1}) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h ins=%h cnt=%0d want 3008 33334444 %0d",
               D_PC, D_Instr, D_FetchCnt, held_cnt + 1);
    end
  endtask

  task automatic test_flush();
    drive(32'h3010, 32'h5555_6666, 0, 1, 1, 0);
    tick();
    vectors++;
    if ({D_PC, D_Instr, D_Valid, D_FetchCnt} !== {32'h3008, 32'h3333_4444, 1'b1, m_cnt}) begin
      miscompares++;
      $display("FAIL stall_over_flush: got pc=%h ins=%h v=%b want 3008 33334444 1",
               D_PC, D_Instr, D_Valid);
    end
    drive(32'h300C, 32'h7777_8888, 1, 0, 1, 0);
    tick();
    vectors++;
    if ({D_PC, D_BD, D_Instr, D_Valid, D_ExcCode, D_FetchCnt} !==
        {32'h300C, 1'b1, 32'h0, 1'b0, 5'd0, m_cnt}) begin
      miscompares++;
      $display("FAIL flush_bubble: got pc=%h bd=%b ins=%h v=%b exc=%0d cnt=%0d want 300c 1 0 0 0 %0d",
               D_PC, D_BD, D_Instr, D_Valid, D_ExcCode, D_FetchCnt, m_cnt);
    end
  endtask

  task automatic test_req();
    drive(32'h3020, 32'h9999_AAAA, 1, 1, 1, 1);
    tick();
    vectors++;
    if ({D_PC, D_Instr, D_BD, D_Valid, D_ExcCode, D_FetchCnt} !==
        {32'h4180, 32'h0, 1'b0, 1'b0, 5'd0, m_cnt}) begin
      miscompares++;
      $display("FAIL req_priority: got pc=%h ins=%h bd=%b v=%b exc=%0d cnt=%0d want 4180 0 0 0 0 %0d",
               D_PC, D_Instr, D_BD, D_Valid, D_ExcCode, D_FetchCnt, m_cnt);
    end
    drive(32'h3000, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: pc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
        1: pc = 32'h3000 + $urandom_range(0, 32'h3FFF);
        2: pc = $urandom_range(0, 32'h2FFF);
        3: pc = 32'h7000 + $urandom_range(0, 32'hFFFF);
        4: pc = 32'h6FFC;
        5: pc = 32'h2FFC;
        6: pc = $urandom;
        default: pc = 32'h3000 + ($urandom_range(0, 32'h3FF) << 2);
      endcase
      drive(pc, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      tick();
      vectors++;
      if ({D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt} !==
          {m_pc, m_instr, m_bd, m_exc, m_vld, m_cnt}) begin
        miscompares++;
        $display("FAIL random_%0d: got pc=%h ins=%h bd=%b exc=%0d v=%b cnt=%0d want pc=%h ins=%h bd=%b exc=%0d v=%b cnt=%0d",
                 i, D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt,
                 m_pc, m_instr, m_bd, m_exc, m_vld, m_cnt);
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    drive(32'h3040, 32'h0BAD_F00D, 0, 1, 0, 0);
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    stall = 0;
    tick();
    vectors++;
    if ({D_FetchCnt, D_PC, D_Valid} !== {32'h0, 32'h3040, 1'b1}) begin
      miscompares++;
      $display("FAIL cnt_wrap: got cnt=%h pc=%h v=%b want 00000000 3040 1", D_FetchCnt, D_PC, D_Valid);
    end
    // reset mid-stall, between edges: must clear without a clock edge
    drive(32'h3044, 32'h1234_5678, 1, 1, 1, 0);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt} !==
        {32'h3000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got pc=%h ins=%h bd=%b exc=%0d v=%b cnt=%0d want 3000 0 0 0 0 0",
               D_PC, D_Instr, D_BD, D_ExcCode, D_Valid, D_FetchCnt);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(32'h3048, 32'hCAFE_0001, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({D_PC, D_Instr, D_Valid, D_FetchCnt} !== {32'h3048, 32'hCAFE_0001, 1'b1, 32'd1}) begin
      miscompares++;
      $display("FAIL post_reset_load: got pc=%h ins=%h v=%b cnt=%0d want 3048 cafe0001 1 1",
               D_PC, D_Instr, D_Valid, D_FetchCnt);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_adel();
    test_stall();
    test_flush();
    test_req();
    test_random();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
